// File: rtl/isa_decode_stage.sv
// RISC-V decode stage: splits the instruction into fields, builds the sign-extended immediate and flags illegal encodings.
// One cycle latency; a two-entry output/skid register pair keeps full throughput under iReady backpressure.
module isa_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit EN_RV64 = (XLEN == 64)
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iFlush,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iINS,
    input  logic [XLEN-1:0] iPC,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oPC,
    output logic [6:0]      oOpCode,
    output logic [4:0]      oRS1,
    output logic [4:0]      oRS2,
    output logic [4:0]      oRD,
    output logic [2:0]      oFunc3,
    output logic [6:0]      oFunc7,
    output logic [XLEN-1:0] oImm,
    output logic [2:0]      oImmType,
    output logic            oRS1En,
    output logic            oRS2En,
    output logic            oRDEn,
    output logic            oIllegal
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [2:0]      imm_type;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_en;
        logic            illegal;
    } dec_t;

    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
    logic [2:0]  w_type;
    logic        w_legal, w_illegal, w_rs1, w_rs2, w_rd;
    logic        w_in_xfer;
    dec_t        w_dec;

    dec_t        r_out, r_skd;
    logic        r_out_vld, r_skd_vld;

    assign w_imm_i = {{21{iINS[31]}}, iINS[30:20]};
    assign w_imm_s = {{21{iINS[31]}}, iINS[30:25], iINS[11:7]};
    assign w_imm_b = {{20{iINS[31]}}, iINS[7], iINS[30:25], iINS[11:8], 1'b0};
    assign w_imm_u = {iINS[31:12], 12'b0};
    assign w_imm_j = {{12{iINS[31]}}, iINS[19:12], iINS[20], iINS[30:21], 1'b0};

    always_comb begin
        w_type  = IMM_NONE;
        w_legal = 1'b1;
        w_rs1   = 1'b0;
        w_rs2   = 1'b0;
        w_rd    = 1'b0;
        case (iINS[6:0])
            7'b0110111, 7'b0010111: begin w_type = IMM_U; w_rd = 1'b1; end
            7'b1101111:             begin w_type = IMM_J; w_rd = 1'b1; end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                w_type = IMM_I; w_rs1 = 1'b1; w_rd = 1'b1;
            end
            7'b1100011: begin w_type = IMM_B; w_rs1 = 1'b1; w_rs2 = 1'b1; end
            7'b0100011: begin w_type = IMM_S; w_rs1 = 1'b1; w_rs2 = 1'b1; end
            7'b0110011: begin w_rs1 = 1'b1; w_rs2 = 1'b1; w_rd = 1'b1; end
            7'b0011011: begin
                w_legal = EN_RV64;
                w_type  = IMM_I; w_rs1 = 1'b1; w_rd = 1'b1;
            end
            7'b0111011: begin
                w_legal = EN_RV64;
                w_rs1 = 1'b1; w_rs2 = 1'b1; w_rd = 1'b1;
            end
            7'b0001111, 7'b1110011: w_type = IMM_I;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_illegal = !w_legal || (iINS[1:0] != 2'b11) || (iINS == 32'h0);

    always_comb begin
        case (w_type)
            IMM_I:   w_imm32 = w_imm_i;
            IMM_S:   w_imm32 = w_imm_s;
            IMM_B:   w_imm32 = w_imm_b;
            IMM_U:   w_imm32 = w_imm_u;
            IMM_J:   w_imm32 = w_imm_j;
            default: w_imm32 = 32'h0;
        endcase
    end

    // Illegal encodings keep their raw fields but carry no immediate or operand enables.
    always_comb begin
        w_dec          = '0;
        w_dec.pc       = iPC;
        w_dec.opcode   = iINS[6:0];
        w_dec.rs1      = iINS[19:15];
        w_dec.rs2      = iINS[24:20];
        w_dec.rd       = iINS[11:7];
        w_dec.func3    = iINS[14:12];
        w_dec.func7    = iINS[31:25];
        w_dec.illegal  = w_illegal;
        w_dec.imm      = w_illegal ? '0 : XLEN'($signed(w_imm32));
        w_dec.imm_type = w_illegal ? IMM_NONE : w_type;
        w_dec.rs1_en   = w_rs1 && !w_illegal;
        w_dec.rs2_en   = w_rs2 && !w_illegal;
        w_dec.rd_en    = w_rd && !w_illegal && (iINS[11:7] != 5'd0);
    end

    assign w_in_xfer = iValid && !r_skd_vld;

    // The skid entry is only ever filled while the output entry is valid and stalled.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_skd     <= '0;
            r_skd_vld <= 1'b0;
        end else if (iFlush) begin
            r_out_vld <= 1'b0;
            r_skd_vld <= 1'b0;
        end else if (r_skd_vld) begin
            if (iReady) begin
                r_out     <= r_skd;
                r_skd_vld <= 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_out_vld || iReady) begin
                r_out     <= w_dec;
                r_out_vld <= 1'b1;
            end else begin
                r_skd     <= w_dec;
                r_skd_vld <= 1'b1;
            end
        end else if (iReady) begin
            r_out_vld <= 1'b0;
        end
    end

    assign oReady   = !r_skd_vld;
    assign oValid   = r_out_vld;
    assign oPC      = r_out.pc;
    assign oOpCode  = r_out.opcode;
    assign oRS1     = r_out.rs1;
    assign oRS2     = r_out.rs2;
    assign oRD      = r_out.rd;
    assign oFunc3   = r_out.func3;
    assign oFunc7   = r_out.func7;
    assign oImm     = r_out.imm;
    assign oImmType = r_out.imm_type;
    assign oRS1En   = r_out.rs1_en;
    assign oRS2En   = r_out.rs2_en;
    assign oRDEn    = r_out.rd_en;
    assign oIllegal = r_out.illegal;

endmodule

// File: doc/isa_decode_stage.md
Name: isa_decode_stage

Overview:
- Registered, handshaked RISC-V instruction decode stage sitting between fetch and register-read/execute.
- Splits the 32-bit instruction into its fields and selects the single immediate the opcode requires, sign-extended to XLEN.
- Flags illegal encodings and produces per-operand register-use enables.
- Two-entry skid buffer gives full throughput under valid/ready backpressure; supports pipeline flush.

Parameters:
XLEN, 32, datapath/PC width; legal values 32 or 64
EN_RV64, (XLEN==64), when 1, OP-IMM-32 (0011011) and OP-32 (0111011) decode as legal

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  asynchronous active-low reset
iFlush  in  1  discard all held and incoming instructions
iValid  in  1  upstream instruction valid
oReady  out  1  stage can accept an instruction this cycle
iINS  in  32  instruction word
iPC  in  XLEN  instruction address
oValid  out  1  decoded instruction valid
iReady  in  1  downstream accepts this cycle
oPC  out  XLEN  PC of the decoded instruction
oOpCode  out  7  iINS[6:0]
oRS1, oRS2, oRD  out  5 each  iINS[19:15], [24:20], [11:7]
oFunc3  out  3  iINS[14:12]
oFunc7  out  7  iINS[31:25]
oImm  out  XLEN  selected, sign-extended immediate (zero for R-type and illegal)
oImmType  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
oRS1En, oRS2En, oRDEn  out  1 each  operand use flags
oIllegal  out  1  illegal encoding

Behaviour:
- Reset (iRst_n low, asynchronous): oValid=0, skid valid=0, oReady=1, all data outputs 0.
- Transfers: input transfer = iValid & oReady; output transfer = oValid & iReady.
- Latency: one cycle. An instruction accepted at edge N is presented on the outputs after edge N.
- Decode logic is combinational on iINS. The results are written into the output register, or into the skid register when the output register is stalled.
- Skid buffer:
  - oReady is registered and equals !skid_valid.
  - If input transfers while oValid & !iReady, the decoded word goes to the skid register.
  - When the output drains, the skid register moves to the output register on the next edge.
  - With no stall, the output register loads directly.
  - Simultaneous accept and drain with skid empty: the output register is replaced with no bubble.
  - Accepting never overwrites a valid output or skid entry (no loss, no duplication).
- Flush: iFlush high at an edge clears oValid and skid_valid, and the input that cycle is dropped. oReady=1 the following cycle. Flush has priority over every other event.
- Immediate formats, by opcode:
  - I: {sext(ins[31]), ins[30:20]}
  - S: {sext(ins[31]), ins[30:25], ins[11:7]}
  - B: {sext(ins[31]), ins[7], ins[30:25], ins[11:8], 0}
  - U: {sext(ins[31]), ins[30:12], 12'b0}; for XLEN=64, bits 63:32 replicate ins[31]
  - J: {sext(ins[31]), ins[19:12], ins[20], ins[30:21], 0}
- Opcode map:

  | Opcode | Class | ImmType | RS1En | RS2En | RDEn |
  |---|---|---|---|---|---|
  | 0110111 | LUI | U | 0 | 0 | 1 |
  | 0010111 | AUIPC | U | 0 | 0 | 1 |
  | 1101111 | JAL | J | 0 | 0 | 1 |
  | 1100111 | JALR | I | 1 | 0 | 1 |
  | 1100011 | BRANCH | B | 1 | 1 | 0 |
  | 0000011 | LOAD | I | 1 | 0 | 1 |
  | 0100011 | STORE | S | 1 | 1 | 0 |
  | 0010011, 0011011* | OP-IMM | I | 1 | 0 | 1 |
  | 0110011, 0111011* | OP | none | 1 | 1 | 1 |
  | 0001111 | MISC-MEM | I | 0 | 0 | 0 |
  | 1110011 | SYSTEM | I | 0 | 0 | 0 |

  *0011011 and 0111011 apply only when EN_RV64=1.
- Register-use qualification: oRDEn is additionally forced 0 when rd==0.
- Illegal (oIllegal=1, all enables 0, oImm=0, oImmType=0):
  - ins[1:0]!=2'b11
  - opcode not in the map
  - iINS==32'h0
  - illegal instructions still flow through the handshake normally.
- oPC: registered copy of iPC, held alongside its instruction through the skid path.
- All data outputs hold their value while oValid & !iReady.

Test Plan:
- Reset: hold iRst_n low mid-stream with skid full -> immediately oValid=0, oReady=1, oImm=0; after release, the first accepted instruction appears one cycle later.
- Immediate formats (XLEN=32, iReady=1):
  - 0xFFF10093 -> oImm=0xFFFFFFFF, type I, rd=1, rs1=2, oRDEn=1.
  - 0xFE000EE3 -> oImm=0xFFFFFFFC, type B, oRDEn=0.
  - 0x123452B7 -> oImm=0x12345000, type U, rd=5.
  - 0x001000EF -> oImm=0x00000800, type J.
  - 0xFE322C23 -> oImm=0xFFFFFFF8, type S, rs1=4, rs2=3.
- Backpressure: stream PCs 0x0,0x4,0x8,0xC with iValid=1; drop iReady for 3 cycles after the first output -> oReady low after the skid fills; outputs appear in order 0x0,0x4,0x8,0xC with none lost or duplicated; full throughput once iReady returns.
- Flush: skid and output both valid, assert iFlush with iValid=1 -> next cycle oValid=0, oReady=1, and the flushed-cycle instruction never appears.
- Illegal detection:
  - 0x00000000 and 0x0000007F -> oIllegal=1, oImm=0, all enables 0.
  - 0x0000001B: with XLEN=32 -> oIllegal=1; with XLEN=64 -> legal, type I.
- XLEN=64: 0xFFF10093 -> oImm=0xFFFFFFFFFFFFFFFF; 0x800002B7 -> oImm=0xFFFFFFFF80000000; oPC carries 64-bit 0x0000_0001_0000_0000 unchanged.
